// File: rtl/wb_pkg.sv
// Shared Wishbone widths, slave FSM state type and byte-lane merge helper.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck,
    StErr
  } wb_slave_state_t;

  function automatic logic [WB_DATA_W-1:0] wb_byte_merge(
    input logic [WB_DATA_W-1:0] old_word,
    input logic [WB_DATA_W-1:0] new_word,
    input logic [WB_SEL_W-1:0]  sel
  );
    logic [WB_DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < WB_SEL_W; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_sram_array.sv
// Single-port behavioural SRAM: synchronous read, byte-masked write, no reset.
module wb_sram_array
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [WB_SEL_W-1:0]  sel,
  input  logic [IDX_W-1:0]     index,
  input  logic [WB_DATA_W-1:0] wdata,
  output logic [WB_DATA_W-1:0] rdata
);

  logic [WB_DATA_W-1:0] mem [DEPTH_WORDS];

  // rdata only moves on a read, so it holds the last read word across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[index] <= wb_byte_merge(mem[index], wdata, sel);
      else    rdata      <= mem[index];
    end
  end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 classic 32-bit slave over an on-chip SRAM with programmable wait states.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned          DEPTH_WORDS = 256,
  parameter int unsigned          WAIT_STATES = 1
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 wb_cyc_in,
  input  logic                 wb_stb_in,
  input  logic                 wb_we_in,
  input  logic [WB_ADDR_W-1:0] wb_adr_in,
  input  logic [WB_DATA_W-1:0] wb_dat_in,
  input  logic [WB_SEL_W-1:0]  wb_sel_in,
  output logic [WB_DATA_W-1:0] wb_dat_out,
  output logic                 wb_ack_out,
  output logic                 wb_err_out
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam bit NoWait = (WAIT_STATES == 0);

  wb_slave_state_t      state_q;
  logic [CntW-1:0]      cnt_q;
  logic                 ack_q, err_q, dat_vld_q, we_q;
  logic [IdxW-1:0]      idx_q;
  logic [WB_DATA_W-1:0] dat_q;
  logic [WB_SEL_W-1:0]  sel_q;

  logic                 req, hit, cnt_done, go_ack, go_err, idle;
  logic                 mem_we;
  logic [IdxW-1:0]      mem_idx;
  logic [WB_DATA_W-1:0] mem_wdata, mem_rdata;
  logic [WB_SEL_W-1:0]  mem_sel;

  // BASE_ADDR is window-aligned, so range decode is a tag compare on the upper bits.
  always_comb begin
    req      = wb_cyc_in & wb_stb_in;
    hit      = (wb_adr_in[WB_ADDR_W-1:IdxW+2] == BASE_ADDR[WB_ADDR_W-1:IdxW+2]) &&
               (wb_adr_in[1:0] == 2'b00);
    cnt_done = (cnt_q == CntLast);
    idle     = (state_q == StIdle);
    go_ack   = 1'b0;
    go_err   = 1'b0;
    case (state_q)
      StIdle: begin
        go_ack = req & hit & NoWait;
        go_err = req & ~hit;
      end
      StWait:  go_ack = wb_cyc_in & cnt_done;
      default: ;
    endcase
    // With no wait states the access happens at the sampling edge, before the latch.
    mem_we    = idle ? wb_we_in                   : we_q;
    mem_idx   = idle ? wb_adr_in[IdxW+1:2]        : idx_q;
    mem_wdata = idle ? wb_dat_in                  : dat_q;
    mem_sel   = idle ? wb_sel_in                  : sel_q;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_vld_q <= 1'b0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
    end else begin
      ack_q <= go_ack;
      err_q <= go_err;
      if (go_ack && !mem_we) dat_vld_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (req) begin
            we_q  <= wb_we_in;
            idx_q <= wb_adr_in[IdxW+1:2];
            dat_q <= wb_dat_in;
            sel_q <= wb_sel_in;
            cnt_q <= '0;
            if (!hit)       state_q <= StErr;
            else if (NoWait) state_q <= StAck;
            else            state_q <= StWait;
          end
        end
        StWait: begin
          if (!wb_cyc_in)    state_q <= StIdle;
          else if (cnt_done) state_q <= StAck;
          else               cnt_q   <= cnt_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  wb_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IdxW)
  ) u_array (
    .clk   (clk_in),
    .en    (go_ack),
    .we    (mem_we),
    .sel   (mem_sel),
    .index (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Flag keeps the output at zero from reset until the first real read.
  assign wb_dat_out = dat_vld_q ? mem_rdata : '0;
  assign wb_ack_out = ack_q;
  assign wb_err_out = err_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed plus random bench for wb_sram_slave, two instances (2 and 0 wait states).
module tb_wb_sram_slave;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cyc_a = 0, stb_a = 0, cyc_b = 0, stb_b = 0, we = 0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, err_a, ack_b, err_b;

  wb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut (
    .clk_in(clk), .reset_in(rst_n), .wb_cyc_in(cyc_a), .wb_stb_in(stb_a), .wb_we_in(we),
    .wb_adr_in(adr), .wb_dat_in(wdat), .wb_sel_in(sel), .wb_dat_out(dat_a),
    .wb_ack_out(ack_a), .wb_err_out(err_a)
  );

  wb_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk_in(clk), .reset_in(rst_n), .wb_cyc_in(cyc_b), .wb_stb_in(stb_b), .wb_we_in(we),
    .wb_adr_in(adr), .wb_dat_in(wdat), .wb_sel_in(sel), .wb_dat_out(dat_b),
    .wb_ack_out(ack_b), .wb_err_out(err_b)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] last_rd [2] = '{32'h0, 32'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit mapped(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 4 * DEPTH) && (a % 4 == 0);
  endfunction

  task automatic drive_req(input int t, input logic v);
    if (t == 0) begin cyc_a = v; stb_a = v; end
    else        begin cyc_b = v; stb_b = v; end
  endtask

  // t=0 -> 2 wait states, t=1 -> 0 wait states. Called #1 after a clock edge.
  task automatic xfer(input int t, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit keep, input string tag);
    int ws, lat, idx;
    bit bad;
    logic oa, oe;
    logic [31:0] od;
    ws  = (t == 0) ? 2 : 0;
    bad = !mapped(a);
    lat = bad ? 1 : ws + 1;
    idx = bad ? 0 : int'((a - BASE) >> 2);
    we = w; adr = a; wdat = d; sel = s;
    drive_req(t, 1'b1);
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk); #1;
      if (k == lat && !bad) begin
        if (w) begin
          for (int b = 0; b < 4; b++) if (s[b]) mem_m[t][idx][8*b +: 8] = d[8*b +: 8];
        end else begin
          last_rd[t] = mem_m[t][idx];
        end
      end
      oa = (t == 0) ? ack_a : ack_b;
      oe = (t == 0) ? err_a : err_b;
      od = (t == 0) ? dat_a : dat_b;
      chk({tag, ".ack"}, {31'd0, oa}, {31'd0, (k == lat) && !bad});
      chk({tag, ".err"}, {31'd0, oe}, {31'd0, (k == lat) && bad});
      chk({tag, ".dat"}, od, last_rd[t]);
      if (k == lat && !keep) drive_req(t, 1'b0);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk({tag, ".ack"}, {31'd0, ack_a}, 32'd0);
      chk({tag, ".err"}, {31'd0, err_a}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] r1, r2, ra, rd;
    logic [3:0]  rs;
    int          r;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ack", {31'd0, ack_a}, 32'd0);
    chk("rst.err", {31'd0, err_a}, 32'd0);
    chk("rst.dat", dat_a, 32'd0);
    chk("rst.dat0", dat_b, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Clear the whole array so every later read has a known value.
    for (int i = 0; i < DEPTH; i++) xfer(0, 1'b1, BASE + 32'(4 * i), 32'h0, 4'hF, 1'b0, "init");

    // 1: full-word write then read, ack at E+3
    xfer(0, 1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, "t1.wr");
    xfer(0, 1'b0, 32'h0001_0004, 32'h0, 4'h0, 1'b0, "t1.rd");
    chk("t1.val", dat_a, 32'hDEAD_BEEF);

    // 2: single byte lane write
    xfer(0, 1'b1, 32'h0001_0004, 32'h0000_AA00, 4'b0010, 1'b0, "t2.wr");
    xfer(0, 1'b0, 32'h0001_0004, 32'h0, 4'h0, 1'b0, "t2.rd");
    chk("t2.val", dat_a, 32'hDEAD_AAEF);

    // 2b: sel=0 write is acked but leaves memory alone
    xfer(0, 1'b1, 32'h0001_0004, 32'hFFFF_FFFF, 4'b0000, 1'b0, "t2b.wr");
    xfer(0, 1'b0, 32'h0001_0004, 32'h0, 4'h0, 1'b0, "t2b.rd");

    // 3: out of range and misaligned -> err after one cycle, data held
    xfer(0, 1'b0, 32'h0001_0400, 32'h0, 4'h0, 1'b0, "t3.oor");
    xfer(0, 1'b0, 32'h0001_0006, 32'h0, 4'h0, 1'b0, "t3.mis");
    xfer(0, 1'b0, 32'h0000_FFFC, 32'h0, 4'h0, 1'b0, "t3.low");
    chk("t3.hold", dat_a, 32'hDEAD_AAEF);

    // 4: abort a write during WAIT
    we = 1'b1; adr = 32'h0001_0008; wdat = 32'h1234_5678; sel = 4'hF;
    drive_req(0, 1'b1);
    @(posedge clk); #1;
    chk("t4.ack", {31'd0, ack_a}, 32'd0);
    chk("t4.err", {31'd0, err_a}, 32'd0);
    drive_req(0, 1'b0);
    idle_cycles(4, "t4.idle");
    xfer(0, 1'b0, 32'h0001_0008, 32'h0, 4'h0, 1'b0, "t4.rd");
    chk("t4.val", dat_a, 32'h0);

    // 5: reset asserted while a read is waiting
    we = 1'b0; adr = 32'h0001_0004;
    drive_req(0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5.ack", {31'd0, ack_a}, 32'd0);
    chk("t5.err", {31'd0, err_a}, 32'd0);
    chk("t5.dat", dat_a, 32'd0);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    drive_req(0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(4, "t5.idle");
    chk("t5.dat2", dat_a, 32'd0);
    xfer(0, 1'b0, 32'h0001_0004, 32'h0, 4'h0, 1'b0, "t5.rd");
    chk("t5.val", dat_a, 32'hDEAD_AAEF);

    // 6: zero wait states, stb held across two reads
    r1 = $urandom;
    r2 = $urandom;
    xfer(1, 1'b1, 32'h0001_0000, r1, 4'hF, 1'b0, "t6.wr0");
    xfer(1, 1'b1, 32'h0001_0004, r2, 4'hF, 1'b0, "t6.wr1");
    xfer(1, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b1, "t6.rd0");
    chk("t6.val0", dat_b, r1);
    xfer(1, 1'b0, 32'h0001_0004, 32'h0, 4'h0, 1'b0, "t6.rd1");
    chk("t6.val1", dat_b, r2);

    // Random traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       ra = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (r == 7) ra = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      else if (r == 8) ra = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 63));
      else             ra = BASE - 32'(4 * $urandom_range(1, 64));
      rd = $urandom;
      rs = 4'($urandom_range(0, 15));
      xfer(0, 1'($urandom_range(0, 1)), ra, rd, rs, 1'b0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
